uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_cmd_timeout.sv | 36 +++
 rtl/uart_cmd_parser.sv | 165 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
// The S_ACK state exists only when UART_CMD_WR_ACK_EN is defined.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR_DEF = 8'h57;
  localparam logic [7:0] CMD_RD_DEF = 8'h52;
  localparam logic [7:0] ACK_BYTE   = 8'h06;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WADDR,
    S_WDATA,
    S_WRITE,
    S_RADDR,
    S_READ,
    S_RWAIT,
    S_TX
`ifdef UART_CMD_WR_ACK_EN
    , S_ACK
`endif
  } state_e;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Clearable idle counter; tc_o pulses in the cycle whose edge completes
// TIMEOUT_CYC consecutive enabled cycles without a clear.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The edge that would take the count to TIMEOUT_CYC is the expiry edge.
  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !en_i || tc_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Binary W/R command decoder between the UART and the 8-bit register file.
// Define UART_CMD_WR_ACK_EN to return an ACK byte (8'h06) after each write.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD      = CMD_RD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [7:0] addr_o,
  output logic [7:0] wdata_o,
  output logic       wen_o,
  output logic       ren_o,
  input  logic [7:0] rdata_i,
  output logic       busy_o,
  output logic [7:0] err_cnt_o
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] err_q, err_d;
  logic       err_inc;
  logic       tmo_en;
  logic       tmo_tc;

  assign tmo_en = (state_q == S_WADDR) || (state_q == S_WDATA) || (state_q == S_RADDR);

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .en_i (tmo_en),
    .clr_i(rx_valid_i),
    .tc_o (tmo_tc)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid_i) begin
          if (rx_data_i == CMD_WR) begin
            state_d = S_WADDR;
          end else if (rx_data_i == CMD_RD) begin
            state_d = S_RADDR;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_WADDR: begin
        if (rx_valid_i) begin
          addr_d  = rx_data_i;
          state_d = S_WDATA;
        end else if (tmo_tc) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (rx_valid_i) begin
          wdata_d = rx_data_i;
          state_d = S_WRITE;
        end else if (tmo_tc) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RADDR: begin
        if (rx_valid_i) begin
          addr_d  = rx_data_i;
          state_d = S_READ;
        end else if (tmo_tc) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      // From here on the receiver cannot be stalled: any byte is an overrun.
      S_WRITE: begin
        err_inc = rx_valid_i;
`ifdef UART_CMD_WR_ACK_EN
        tx_data_d  = ACK_BYTE;
        tx_valid_d = 1'b1;
        state_d    = S_ACK;
`else
        state_d    = S_IDLE;
`endif
      end
      S_READ: begin
        err_inc = rx_valid_i;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        err_inc    = rx_valid_i;
        tx_data_d  = rdata_i;
        tx_valid_d = 1'b1;
        state_d    = S_TX;
      end
      S_TX: begin
        err_inc = rx_valid_i;
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`ifdef UART_CMD_WR_ACK_EN
      S_ACK: begin
        err_inc = rx_valid_i;
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign wen_o      = (state_q == S_WRITE);
  assign ren_o      = (state_q == S_READ);
  assign busy_o     = (state_q != S_IDLE);
  assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser with a reduced timeout; inputs change
// and outputs are sampled on the falling clock edge.
module tb_uart_cmd_parser;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic [7:0] addr_o;
  logic [7:0] wdata_o;
  logic       wen_o;
  logic       ren_o;
  logic [7:0] rdata_i;
  logic       busy_o;
  logic [7:0] err_cnt_o;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;
  int wen_exp = 0;
  int ren_exp = 0;
  int wen_seen = 0;
  int ren_seen = 0;
  int overlap = 0;

  logic [7:0] exp_mem [256];
  logic [7:0] regfile [256];
  logic       rd_pend = 1'b0;
  logic [7:0] rd_addr = 8'h00;

  uart_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .addr_o    (addr_o),
    .wdata_o   (wdata_o),
    .wen_o     (wen_o),
    .ren_o     (ren_o),
    .rdata_i   (rdata_i),
    .busy_o    (busy_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk = ~clk;

  // External register file: data is valid only during the cycle after ren_o.
  always @(negedge clk) begin
    if (wen_o) regfile[addr_o] = wdata_o;
    if (rd_pend) begin
      rdata_i = regfile[rd_addr];
      rd_pend = 1'b0;
    end else begin
      rdata_i = 8'($urandom);
    end
    if (ren_o) begin
      rd_pend = 1'b1;
      rd_addr = addr_o;
    end
    if (wen_o) wen_seen++;
    if (ren_o) ren_seen++;
    if (wen_o && ren_o) overlap++;
  end

  function automatic logic [7:0] err_model();
    return (err_exp > 255) ? 8'hFF : 8'(err_exp);
  endfunction

  // Called at a falling edge; the byte is strobed at the next rising edge.
  task automatic send(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered in the S_WRITE cycle; leaves the parser idle.
  task automatic finish_write();
`ifdef UART_CMD_WR_ACK_EN
    @(negedge clk);
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h06) begin
      errors++;
      $display("FAIL ack_byte valid=%b data=%h expected valid=1 data=06", tx_valid_o, tx_data_o);
    end
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
`else
    @(negedge clk);
`endif
  endtask

  function automatic logic [7:0] bad_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h57 || b == 8'h52) b = 8'h11;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    checks++;
    if ({tx_data_o, tx_valid_o, addr_o, wdata_o, wen_o, ren_o, busy_o, err_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got tx=%h v=%b a=%h d=%h wen=%b ren=%b busy=%b err=%h expected all 0",
               tx_data_o, tx_valid_o, addr_o, wdata_o, wen_o, ren_o, busy_o, err_cnt_o);
    end
  endtask

  task automatic test_write();
    send(8'h57);
    send(8'h3C);
    send(8'hA5);
    checks++;
    if (wen_o !== 1'b1 || ren_o !== 1'b0 || addr_o !== 8'h3C || wdata_o !== 8'hA5) begin
      errors++;
      $display("FAIL write_strobe wen=%b ren=%b addr=%h wdata=%h expected wen=1 ren=0 addr=3c wdata=a5",
               wen_o, ren_o, addr_o, wdata_o);
    end
    exp_mem[8'h3C] = 8'hA5;
    wen_exp++;
    finish_write();
    checks++;
    if (wen_o !== 1'b0 || busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL write_done wen=%b busy=%b txv=%b expected 0 0 0", wen_o, busy_o, tx_valid_o);
    end
    idle(3);
    checks++;
    if (tx_valid_o !== 1'b0 || wdata_o !== 8'hA5 || addr_o !== 8'h3C) begin
      errors++;
      $display("FAIL write_hold txv=%b addr=%h wdata=%h expected 0 3c a5", tx_valid_o, addr_o, wdata_o);
    end
  endtask

  task automatic test_read();
    send(8'h52);
    send(8'h3C);
    checks++;
    if (ren_o !== 1'b1 || wen_o !== 1'b0) begin
      errors++;
      $display("FAIL read_strobe ren=%b wen=%b expected 1 0", ren_o, wen_o);
    end
    ren_exp++;
    @(negedge clk);
    checks++;
    if (ren_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL read_wait ren=%b txv=%b expected 0 0", ren_o, tx_valid_o);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== exp_mem[8'h3C]) begin
        errors++;
        $display("FAIL read_hold cycle %0d txv=%b data=%h expected 1 %h", i, tx_valid_o, tx_data_o,
                 exp_mem[8'h3C]);
      end
      if (i < 5) @(negedge clk);
    end
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
    checks++;
    if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL read_accept txv=%b busy=%b expected 0 0", tx_valid_o, busy_o);
    end
  endtask

  task automatic test_bad_opcode();
    send(8'h11);
    err_exp++;
    checks++;
    if (err_cnt_o !== err_model() || busy_o !== 1'b0 || wen_o !== 1'b0 || ren_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_opcode err=%h busy=%b wen=%b ren=%b expected err=%h busy=0 wen=0 ren=0",
               err_cnt_o, busy_o, wen_o, ren_o, err_model());
    end
    send(8'h57);
    send(8'h5A);
    send(8'hC3);
    checks++;
    if (wen_o !== 1'b1 || addr_o !== 8'h5A || wdata_o !== 8'hC3) begin
      errors++;
      $display("FAIL write_after_bad wen=%b addr=%h wdata=%h expected 1 5a c3", wen_o, addr_o, wdata_o);
    end
    exp_mem[8'h5A] = 8'hC3;
    wen_exp++;
    finish_write();
  endtask

  task automatic test_timeout();
    send(8'h57);
    send(8'h10);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b1 || err_cnt_o !== err_model()) begin
        errors++;
        $display("FAIL timeout_early silent=%0d busy=%b err=%h expected 1 %h", i, busy_o, err_cnt_o,
                 err_model());
      end
    end
    @(negedge clk);
    err_exp++;
    checks++;
    if (busy_o !== 1'b0 || err_cnt_o !== err_model() || wen_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_expire busy=%b err=%h wen=%b expected 0 %h 0", busy_o, err_cnt_o, wen_o,
               err_model());
    end
    send(8'h57);
    send(8'h10);
    send(8'h77);
    checks++;
    if (wen_o !== 1'b1 || addr_o !== 8'h10 || wdata_o !== 8'h77) begin
      errors++;
      $display("FAIL write_after_timeout wen=%b addr=%h wdata=%h expected 1 10 77", wen_o, addr_o, wdata_o);
    end
    exp_mem[8'h10] = 8'h77;
    wen_exp++;
    finish_write();
  endtask

  task automatic test_overrun_reset();
    send(8'h52);
    send(8'h10);
    ren_exp++;
    idle(2);
    send(8'hEE);
    err_exp++;
    checks++;
    if (err_cnt_o !== err_model() || tx_valid_o !== 1'b1 || tx_data_o !== 8'h77 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_tx err=%h txv=%b data=%h busy=%b expected %h 1 77 1", err_cnt_o, tx_valid_o,
               tx_data_o, busy_o, err_model());
    end
    tx_ready_i = 1'b1;
    @(negedge clk);
    tx_ready_i = 1'b0;
    send(8'h52);
    send(8'h10);
    ren_exp++;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_exp = 0;
    checks++;
    if (tx_valid_o !== 1'b0 || err_cnt_o !== 8'h00 || busy_o !== 1'b0 || addr_o !== 8'h00 ||
        tx_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_tx txv=%b err=%h busy=%b addr=%h data=%h expected all 0", tx_valid_o,
               err_cnt_o, busy_o, addr_o, tx_data_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      send(bad_byte());
      err_exp++;
      if (i == 253) begin
        checks++;
        if (err_cnt_o !== 8'hFE) begin
          errors++;
          $display("FAIL err_below_sat err=%h expected fe", err_cnt_o);
        end
      end
    end
    checks++;
    if (err_cnt_o !== 8'hFF) begin
      errors++;
      $display("FAIL err_saturate err=%h expected ff", err_cnt_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    err_exp = 0;
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0) return TO - 1;
    if (r == 1) return TO;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    int kind;
    int g;
    logic [7:0] a;
    logic [7:0] d;
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 4));
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      if (kind == 0) begin
        send(bad_byte());
        err_exp++;
      end else if (kind <= 2) begin
        send(8'h57);
        g = pick_gap();
        idle(g);
        if (g >= TO) begin
          err_exp++;
        end else begin
          send(a);
          g = pick_gap();
          idle(g);
          if (g >= TO) begin
            err_exp++;
          end else begin
            send(d);
            checks++;
            if (wen_o !== 1'b1 || addr_o !== a || wdata_o !== d) begin
              errors++;
              $display("FAIL rand_write #%0d wen=%b addr=%h wdata=%h expected 1 %h %h", n, wen_o, addr_o,
                       wdata_o, a, d);
            end
            exp_mem[a] = d;
            wen_exp++;
            finish_write();
          end
        end
      end else begin
        send(8'h52);
        g = pick_gap();
        idle(g);
        if (g >= TO) begin
          err_exp++;
        end else begin
          send(a);
          ren_exp++;
          idle(2);
          for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
            if ($urandom_range(0, 2) == 0) begin
              send(8'($urandom));
              err_exp++;
            end else begin
              @(negedge clk);
            end
          end
          checks++;
          if (tx_valid_o !== 1'b1 || tx_data_o !== exp_mem[a]) begin
            errors++;
            $display("FAIL rand_read #%0d addr=%h txv=%b data=%h expected 1 %h", n, a, tx_valid_o,
                     tx_data_o, exp_mem[a]);
          end
          tx_ready_i = 1'b1;
          @(negedge clk);
          tx_ready_i = 1'b0;
        end
      end
      checks++;
      if (err_cnt_o !== err_model() || busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle #%0d err=%h busy=%b txv=%b expected %h 0 0", n, err_cnt_o, busy_o,
                 tx_valid_o, err_model());
      end
    end
  endtask

  task automatic test_strobe_totals();
    idle(2);
    checks++;
    if (wen_seen !== wen_exp || ren_seen !== ren_exp || overlap !== 0) begin
      errors++;
      $display("FAIL strobe_totals wen=%0d ren=%0d both=%0d expected %0d %0d 0", wen_seen, ren_seen, overlap,
               wen_exp, ren_exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = 8'h00;
      regfile[i] = 8'h00;
    end
    rst        = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    tx_ready_i = 1'b0;
    rdata_i    = 8'h00;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_timeout();
    test_overrun_reset();
    test_saturation();
    test_random();
    test_strobe_totals();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
